vga_pattern_engine: RTL and testbench

//   Parametrised VGA timing + test-pattern engine for the BeagleWire VGA path.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_timing_counter.sv | 69 ++++++
 rtl/vga_pattern_engine.sv | 187 ++++++++++++++++++
 tb/tb_vga_pattern_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern engine: pattern codes, default 640x480@60 timing
// and the line/frame total helper.
package vga_pkg;

    localparam logic [2:0] PAT_BLACK    = 3'd0;
    localparam logic [2:0] PAT_RED      = 3'd1;
    localparam logic [2:0] PAT_GREEN    = 3'd2;
    localparam logic [2:0] PAT_BLUE     = 3'd3;
    localparam logic [2:0] PAT_CHECKER  = 3'd4;
    localparam logic [2:0] PAT_BARS     = 3'd5;
    localparam logic [2:0] PAT_BORDER   = 3'd6;
    localparam logic [2:0] PAT_GRADIENT = 3'd7;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int calc_total(input int active, input int fp, input int sync_w, input int bp);
        return active + fp + sync_w + bp;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Column/row raster counters with combinational sync, DE, frame-start and line-end flags
// decoded from the current counter position.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int CW      = $clog2(H_TOTAL),
    localparam int RW      = $clog2(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_hs_act,
    output logic          o_vs_act,
    output logic          o_de,
    output logic          o_frame_start,
    output logic          o_line_end
);

    localparam logic [CW-1:0] COL_LAST = CW'(H_TOTAL - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_TOTAL - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
            col_d = col_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (i_en) begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Compare as int so a sync window ending exactly at the total never overflows CW bits.
    assign o_hs_act      = (int'(col_q) >= H_ACTIVE + H_FP) &&
                           (int'(col_q) <  H_ACTIVE + H_FP + H_SYNC);
    assign o_vs_act      = (int'(row_q) >= V_ACTIVE + V_FP) &&
                           (int'(row_q) <  V_ACTIVE + V_FP + V_SYNC);
    assign o_de          = (int'(col_q) < H_ACTIVE) && (int'(row_q) < V_ACTIVE);
    assign o_frame_start = (col_q == '0) && (row_q == '0);
    assign o_line_end    = (col_q == COL_LAST);
    assign o_col         = col_q;
    assign o_row         = row_q;

endmodule

// File: rtl/vga_pattern_engine.sv
// VGA timing plus test-pattern generator: pattern is latched at frame start and every
// output is registered one enabled step after the raster position it describes.
module vga_pattern_engine
    import vga_pkg::*;
#(
    parameter int VIDEO_WIDTH  = 3,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BP         = DEF_H_BP,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BP         = DEF_V_BP,
    parameter int SYNC_POL     = 0,
    parameter int CHECKER_LOG2 = 5,
    localparam int H_TOTAL     = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL     = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int CW          = $clog2(H_TOTAL),
    localparam int RW          = $clog2(V_TOTAL)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic [2:0]             i_pattern,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_de,
    output logic [CW-1:0]          o_col,
    output logic [RW-1:0]          o_row,
    output logic                   o_frame_start,
    output logic [VIDEO_WIDTH-1:0] o_red,
    output logic [VIDEO_WIDTH-1:0] o_green,
    output logic [VIDEO_WIDTH-1:0] o_blue
);

    localparam int                     BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic                   SYNC_ACT = (SYNC_POL != 0);
    localparam logic [VIDEO_WIDTH-1:0] FULL     = '1;

    logic [CW-1:0] cnt_col;
    logic [RW-1:0] cnt_row;
    logic          cnt_hs_act;
    logic          cnt_vs_act;
    logic          cnt_de;
    logic          cnt_fs;
    logic          cnt_line_end;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (i_en),
        .o_col         (cnt_col),
        .o_row         (cnt_row),
        .o_hs_act      (cnt_hs_act),
        .o_vs_act      (cnt_vs_act),
        .o_de          (cnt_de),
        .o_frame_start (cnt_fs),
        .o_line_end    (cnt_line_end)
    );

    logic [2:0]             pat_q;
    logic [2:0]             eff_pat;
    logic [2:0]             bar_idx_q, bar_idx_d;
    logic [CW-1:0]          bar_px_q, bar_px_d;
    logic                   hsync_q, vsync_q, de_q, fs_q;
    logic [CW-1:0]          col_q;
    logic [RW-1:0]          row_q;
    logic [VIDEO_WIDTH-1:0] red_q, green_q, blue_q;
    logic [VIDEO_WIDTH-1:0] red_d, green_d, blue_d;
    logic                   ck_col, ck_row, on_border;

    // Pixel (0,0) must already use the newly requested pattern, so bypass the latch there.
    assign eff_pat = cnt_fs ? i_pattern : pat_q;

    // Bar index tracks the counter column; bar 7 saturates and absorbs the remainder pixels.
    always_comb begin
        bar_idx_d = bar_idx_q;
        bar_px_d  = bar_px_q;
        if (cnt_line_end) begin
            bar_idx_d = '0;
            bar_px_d  = '0;
        end else if (bar_idx_q != 3'd7) begin
            if (bar_px_q == CW'(BAR_W - 1)) begin
                bar_idx_d = bar_idx_q + 3'd1;
                bar_px_d  = '0;
            end else begin
                bar_px_d = bar_px_q + 1'b1;
            end
        end
    end

    assign ck_col    = |((cnt_col >> CHECKER_LOG2) & CW'(1));
    assign ck_row    = |((cnt_row >> CHECKER_LOG2) & RW'(1));
    assign on_border = (cnt_col == '0) || (cnt_col == CW'(H_ACTIVE - 1)) ||
                       (cnt_row == '0) || (cnt_row == RW'(V_ACTIVE - 1));

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (cnt_de) begin
            case (eff_pat)
                PAT_RED:   red_d   = FULL;
                PAT_GREEN: green_d = FULL;
                PAT_BLUE:  blue_d  = FULL;
                PAT_CHECKER: begin
                    if (ck_col ^ ck_row) begin
                        red_d   = FULL;
                        green_d = FULL;
                        blue_d  = FULL;
                    end
                end
                PAT_BARS: begin
                    red_d   = {VIDEO_WIDTH{bar_idx_q[2]}};
                    green_d = {VIDEO_WIDTH{bar_idx_q[1]}};
                    blue_d  = {VIDEO_WIDTH{bar_idx_q[0]}};
                end
                PAT_BORDER: begin
                    if (on_border) begin
                        red_d   = FULL;
                        green_d = FULL;
                        blue_d  = FULL;
                    end
                end
                PAT_GRADIENT: begin
                    red_d   = cnt_col[CW-1 -: VIDEO_WIDTH];
                    green_d = cnt_col[CW-1 -: VIDEO_WIDTH];
                    blue_d  = cnt_col[CW-1 -: VIDEO_WIDTH];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pat_q     <= PAT_BLACK;
            bar_idx_q <= '0;
            bar_px_q  <= '0;
            hsync_q   <= ~SYNC_ACT;
            vsync_q   <= ~SYNC_ACT;
            de_q      <= 1'b0;
            fs_q      <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else if (i_en) begin
            if (cnt_fs) begin
                pat_q <= i_pattern;
            end
            bar_idx_q <= bar_idx_d;
            bar_px_q  <= bar_px_d;
            hsync_q   <= cnt_hs_act ? SYNC_ACT : ~SYNC_ACT;
            vsync_q   <= cnt_vs_act ? SYNC_ACT : ~SYNC_ACT;
            de_q      <= cnt_de;
            fs_q      <= cnt_fs;
            col_q     <= cnt_col;
            row_q     <= cnt_row;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_de          = de_q;
    assign o_frame_start = fs_q;
    assign o_col         = col_q;
    assign o_row         = row_q;
    assign o_red         = red_q;
    assign o_green       = green_q;
    assign o_blue        = blue_q;

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Bench for vga_pattern_engine: a default 640x480 instance checked against a table of line
// vectors, and a tiny 16x4 instance checked step by step against a reference model.
module tb_vga_pattern_engine;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       rst;
    logic       en_a, en_b;
    logic [2:0] pat_a, pat_b;

    logic       a_hs, a_vs, a_de, a_fs;
    logic [9:0] a_col, a_row;
    logic [2:0] a_r, a_g, a_b;

    logic       b_hs, b_vs, b_de, b_fs;
    logic [4:0] b_col;
    logic [2:0] b_row;
    logic [2:0] b_r, b_g, b_b;

    int n_checks = 0;
    int n_fail   = 0;

    vga_pattern_engine u_a (
        .i_clk(clk), .i_rst(rst), .i_en(en_a), .i_pattern(pat_a),
        .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de), .o_col(a_col), .o_row(a_row),
        .o_frame_start(a_fs), .o_red(a_r), .o_green(a_g), .o_blue(a_b)
    );

    vga_pattern_engine #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1), .CHECKER_LOG2(1)
    ) u_b (
        .i_clk(clk), .i_rst(rst), .i_en(en_b), .i_pattern(pat_b),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de), .o_col(b_col), .o_row(b_row),
        .o_frame_start(b_fs), .o_red(b_r), .o_green(b_g), .o_blue(b_b)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Small frame: 24 columns x 7 rows = 168 steps.
    function automatic logic [20:0] model_b(input int n, input int pat);
        int col, row, bar;
        logic hs, vs, de, fs, w;
        logic [2:0] r, g, b;
        if (n < 0) return '0;
        col = n % 24;
        row = n / 24;
        hs  = (col >= 18) && (col < 21);
        vs  = (row == 5);
        de  = (col < 16) && (row < 4);
        fs  = (n == 0);
        r = 0; g = 0; b = 0;
        if (de) begin
            case (pat)
                1: r = 7;
                2: g = 7;
                3: b = 7;
                4: begin
                    w = (((col >> 1) & 1) ^ ((row >> 1) & 1)) != 0;
                    r = w ? 7 : 0; g = r; b = r;
                end
                5: begin
                    bar = col / 2;
                    if (bar > 7) bar = 7;
                    r = bar[2] ? 7 : 0;
                    g = bar[1] ? 7 : 0;
                    b = bar[0] ? 7 : 0;
                end
                6: begin
                    w = (col == 0) || (col == 15) || (row == 0) || (row == 3);
                    r = w ? 7 : 0; g = r; b = r;
                end
                7: begin
                    r = 3'((col >> 2) & 7); g = r; b = r;
                end
                default: ;
            endcase
        end
        return {col[4:0], row[2:0], hs, vs, de, fs, r, g, b};
    endfunction

    int bn   = -1;
    int blat = 0;

    task automatic run_b(input int cycles, input bit rnd);
        logic e;
        for (int i = 0; i < cycles; i++) begin
            e = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            en_b = e;
            @(posedge clk);
            #1;
            if (e) begin
                bn = (bn + 1) % 168;
                if (bn == 0) blat = int'(pat_b);
            end
            check($sformatf("b_pix n=%0d pat=%0d en=%0d", bn, blat, e),
                  {b_col, b_row, b_hs, b_vs, b_de, b_fs, b_r, b_g, b_b},
                  model_b(bn, blat));
        end
        en_b = 1'b0;
    endtask

    typedef struct {
        int step; int col; int row;
        int r; int g; int b;
        int hs; int de; int fs;
    } a_vec_t;

    a_vec_t vec[21];

    initial begin
        int k, hs_lo, de_cnt;

        // Pattern 5 bars on line 0 of the default timing, then the start of line 1.
        vec[0]  = '{0,   0,   0, 0, 0, 0, 1, 1, 1};
        vec[1]  = '{79,  79,  0, 0, 0, 0, 1, 1, 0};
        vec[2]  = '{80,  80,  0, 0, 0, 7, 1, 1, 0};
        vec[3]  = '{159, 159, 0, 0, 0, 7, 1, 1, 0};
        vec[4]  = '{160, 160, 0, 0, 7, 0, 1, 1, 0};
        vec[5]  = '{240, 240, 0, 0, 7, 7, 1, 1, 0};
        vec[6]  = '{319, 319, 0, 0, 7, 7, 1, 1, 0};
        vec[7]  = '{320, 320, 0, 7, 0, 0, 1, 1, 0};
        vec[8]  = '{400, 400, 0, 7, 0, 7, 1, 1, 0};
        vec[9]  = '{480, 480, 0, 7, 7, 0, 1, 1, 0};
        vec[10] = '{559, 559, 0, 7, 7, 0, 1, 1, 0};
        vec[11] = '{560, 560, 0, 7, 7, 7, 1, 1, 0};
        vec[12] = '{639, 639, 0, 7, 7, 7, 1, 1, 0};
        vec[13] = '{640, 640, 0, 0, 0, 0, 1, 0, 0};
        vec[14] = '{655, 655, 0, 0, 0, 0, 1, 0, 0};
        vec[15] = '{656, 656, 0, 0, 0, 0, 0, 0, 0};
        vec[16] = '{751, 751, 0, 0, 0, 0, 0, 0, 0};
        vec[17] = '{752, 752, 0, 0, 0, 0, 1, 0, 0};
        vec[18] = '{799, 799, 0, 0, 0, 0, 1, 0, 0};
        vec[19] = '{800, 0,   1, 0, 0, 0, 1, 1, 0};
        vec[20] = '{881, 81,  1, 0, 0, 7, 1, 1, 0};

        rst   = 1'b1;
        en_a  = 1'b1;
        en_b  = 1'b0;
        pat_a = 3'd3;
        pat_b = 3'd6;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Run mid-line with solid blue, then hit reset asynchronously.
        repeat (300) @(posedge clk);
        #1;
        check("a_midline_col", a_col, 299);
        check("a_midline_rgb", {a_r, a_g, a_b}, 9'o007);
        pat_a = 3'd5;
        #5 rst = 1'b1;
        #1;
        check("a_async_rst", {a_col, a_row, a_hs, a_vs, a_de, a_fs, a_r, a_g, a_b},
              {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0});
        repeat (2) @(posedge clk);
        #1;
        check("a_held_rst", {a_col, a_row, a_hs, a_vs, a_de, a_fs, a_r, a_g, a_b},
              {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0});
        check("b_rst_state", {b_col, b_row, b_hs, b_vs, b_de, b_fs, b_r, b_g, b_b}, 21'd0);
        rst = 1'b0;

        k = -1;
        hs_lo = 0;
        de_cnt = 0;
        for (int i = 0; i < 21; i++) begin
            while (k < vec[i].step) begin
                @(posedge clk);
                #1;
                k++;
                if (k < 800) begin
                    if (!a_hs) hs_lo++;
                    if (a_de) de_cnt++;
                end
            end
            check($sformatf("a_col step=%0d", k), a_col, vec[i].col);
            check($sformatf("a_row step=%0d", k), a_row, vec[i].row);
            check($sformatf("a_hsync step=%0d", k), a_hs, vec[i].hs);
            check($sformatf("a_vsync step=%0d", k), a_vs, 1);
            check($sformatf("a_de step=%0d", k), a_de, vec[i].de);
            check($sformatf("a_fs step=%0d", k), a_fs, vec[i].fs);
            check($sformatf("a_rgb step=%0d", k), {a_r, a_g, a_b},
                  {3'(vec[i].r), 3'(vec[i].g), 3'(vec[i].b)});
        end
        en_a = 1'b0;
        check("a_hsync_low_per_line", hs_lo, 96);
        check("a_de_per_line", de_cnt, 640);

        // Small frame: border for two frames, red->green switch mid-frame, then random enable.
        run_b(336, 1'b0);
        pat_b = 3'd1;
        run_b(217, 1'b0);
        pat_b = 3'd2;
        run_b(168, 1'b0);
        pat_b = 3'd4;
        run_b(400, 1'b1);
        pat_b = 3'd5;
        run_b(400, 1'b1);
        pat_b = 3'd7;
        run_b(400, 1'b1);
        pat_b = 3'd3;
        run_b(200, 1'b1);

        // The default instance has been disabled throughout and must not have moved.
        check("a_hold_col", a_col, 81);
        check("a_hold_row", a_row, 1);
        check("a_hold_rgb", {a_r, a_g, a_b}, 9'o007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
